// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, decade limits and the load clamp helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Out-of-range codes (A..F) collapse to 9 so a digit never leaves 0..9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade counter stage; cy flags that this stage wraps on the current enabled step.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       cy
);

  logic at_lim;

  assign at_lim = up_dn ? (q == BCD_MAX) : (q == BCD_MIN);
  assign cy     = en & at_lim;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= bcd_clamp(load_val);
    end else if (en) begin
      if (up_dn) q <= at_lim ? BCD_MIN : q + 4'd1;
      else       q <= at_lim ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit up/down BCD counter with load, wrap or saturate at terminal count,
// sticky overflow and a one-cycle flag for loads that needed clamping.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic all_max;
  logic all_min;
  logic load_bad;
  logic sat_hold;
  logic carry_out;

  // Terminal-count detection and load range check, one decade at a time.
  always_comb begin
    all_max  = 1'b1;
    all_min  = 1'b1;
    load_bad = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      all_max  = all_max & (count[4*k +: 4] == BCD_MAX);
      all_min  = all_min & (count[4*k +: 4] == BCD_MIN);
      load_bad = load_bad | (load_val[4*k +: 4] > BCD_MAX);
    end
  end

  assign tc       = en & ~load & (up_dn ? all_max : all_min);
  assign sat_hold = SATURATE & tc;

  // Carry ripples stage to stage; saturation freezes the whole chain at its source.
  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dig
    logic stage_en;
    logic cy;

    if (k == 0) begin : g_lsd
      assign stage_en = en & ~sat_hold;
    end else begin : g_msd
      assign stage_en = g_dig[k-1].cy;
    end

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (stage_en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val[4*k +: 4]),
      .q        (count[4*k +: 4]),
      .cy       (cy)
    );
  end

  assign carry_out = g_dig[DIGITS-1].cy;

  // A carry out of the top decade is a wrap; sat_hold covers the frozen case.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      ovf      <= 1'b0;
      load_err <= load_bad;
    end else begin
      load_err <= 1'b0;
      if (carry_out | sat_hold) ovf <= 1'b1;
    end
  end

  logic unused_w;
  assign unused_w = ^W;

endmodule
